// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit dynamic branch predictor with tagged target store for the 5-stage MIPS pipeline.
// Optional feature macro: BPRED_STATS_EN adds branch_cnt / miss_cnt statistics outputs.
module branch_predictor #(
    parameter int          ENTRIES  = 16,
    parameter int          IDX_W    = 4,
    parameter logic [1:0]  CTR_INIT = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pcF,
    output logic        pred_takenF,
    output logic [31:0] pred_targetF,
    input  logic        branchD,
    input  logic        stallD,
    input  logic [31:0] pcD,
    input  logic        pred_takenD,
    input  logic        actual_takenD,
    input  logic [31:0] targetD,
    output logic        mispredictD,
    output logic [31:0] recover_pcD
`ifdef BPRED_STATS_EN
    ,
    output logic [31:0] branch_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int TAG_W = 32 - IDX_W - 2;

    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [31:0]      r_target [ENTRIES];
    logic [1:0]       r_ctr    [ENTRIES];

    logic [IDX_W-1:0] w_rdIdx;
    logic [TAG_W-1:0] w_rdTag;
    logic             w_rdHit;
    logic [IDX_W-1:0] w_wrIdx;
    logic [TAG_W-1:0] w_wrTag;
    logic             w_wrHit;
    logic             w_update;

    assign w_rdIdx = pcF[IDX_W+1:2];
    assign w_rdTag = pcF[31:IDX_W+2];
    assign w_rdHit = r_valid[w_rdIdx] && (r_tag[w_rdIdx] == w_rdTag);

    // Lookup reads the registered table only, so a same-cycle update is not visible here.
    assign pred_takenF  = w_rdHit & r_ctr[w_rdIdx][1];
    assign pred_targetF = pred_takenF ? r_target[w_rdIdx] : 32'd0;

    assign w_wrIdx  = pcD[IDX_W+1:2];
    assign w_wrTag  = pcD[31:IDX_W+2];
    assign w_wrHit  = r_valid[w_wrIdx] && (r_tag[w_wrIdx] == w_wrTag);
    assign w_update = branchD & ~stallD;

    assign mispredictD = w_update & (pred_takenD != actual_takenD);
    // pcD+8 skips the delay slot that has already been fetched.
    assign recover_pcD = actual_takenD ? targetD : (pcD + 32'd8);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= 32'd0;
                r_ctr[i]    <= CTR_INIT;
            end
        end else if (w_update) begin
            if (actual_takenD) begin
                r_valid[w_wrIdx]  <= 1'b1;
                r_tag[w_wrIdx]    <= w_wrTag;
                r_target[w_wrIdx] <= targetD;
                if (!w_wrHit)
                    r_ctr[w_wrIdx] <= 2'b10;
                else if (r_ctr[w_wrIdx] != 2'b11)
                    r_ctr[w_wrIdx] <= r_ctr[w_wrIdx] + 2'b01;
            end else if (w_wrHit && (r_ctr[w_wrIdx] != 2'b00)) begin
                // A not-taken miss deliberately allocates nothing.
                r_ctr[w_wrIdx] <= r_ctr[w_wrIdx] - 2'b01;
            end
        end
    end

`ifdef BPRED_STATS_EN
    logic [31:0] r_branchCnt;
    logic [31:0] r_missCnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_branchCnt <= 32'd0;
            r_missCnt   <= 32'd0;
        end else begin
            if (w_update)
                r_branchCnt <= r_branchCnt + 32'd1;
            if (mispredictD)
                r_missCnt <= r_missCnt + 32'd1;
        end
    end

    assign branch_cnt = r_branchCnt;
    assign miss_cnt   = r_missCnt;
`endif

endmodule
